// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet receive path.
// Queue entries are {end, start, data[31:0]}.
package eth_pkg;

  // Per-port receive FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    DROP = 2'd2
  } rx_states;

  // Queue word layout
  localparam int QWORD_W = 34;
  localparam int Q_END   = 33;
  localparam int Q_START = 32;

  // Skid depth; also the fill level at which the link is stalled
  localparam int SKID_DEPTH = 2;

  // Statistics counter width
  localparam int CNT_W = 16;

  // Saturating increment: holds at all-ones once reached
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    if (en && (v != {CNT_W{1'b1}})) begin
      return v + CNT_W'(1);
    end
    return v;
  endfunction

endpackage

// File: rtl/eth_rx_skid.sv
// Two-entry skid FIFO between the receive classifier and the port queue.
// The head entry is presented to the queue whenever the FIFO is non-empty
// and the queue is not full. port_stall is registered and looks one word
// ahead so the link partner stops before the FIFO can overflow.
module eth_rx_skid
  import eth_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               push,
  input  logic [QWORD_W-1:0] push_data,
  input  logic               full,
  output logic               wr_en,
  output logic [QWORD_W-1:0] wr_data,
  output logic               stall,
  output logic               overflow
);

  logic [QWORD_W-1:0] mem_reg [SKID_DEPTH];
  logic               rd_ptr_reg;
  logic               wr_ptr_reg;
  logic [1:0]         count_reg;
  logic [1:0]         count_next;
  logic               stall_reg;
  logic               pop;
  logic               accept;

  // A word arriving while both entries are occupied is lost, even if an
  // entry frees up in the same cycle; the stall makes that an upstream bug.
  assign pop      = (count_reg != 2'd0) & ~full;
  assign accept   = push & (count_reg != 2'(SKID_DEPTH));
  assign overflow = push & ~accept;

  assign wr_en    = pop;
  assign wr_data  = mem_reg[rd_ptr_reg];
  assign stall    = stall_reg;

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_next = count_reg + {1'b0, accept} - {1'b0, pop};
  end

  // Storage entries; cleared on reset so wr_data idles at zero
  generate
    for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
      // Capture the incoming word into the entry the write pointer selects
      always_ff @(posedge clk) begin
        if (!rstn) begin
          mem_reg[gi] <= '0;
        end else if (accept && (wr_ptr_reg == 1'(gi))) begin
          mem_reg[gi] <= push_data;
        end
      end
    end
  endgenerate

  // Pointers, occupancy and the look-ahead stall
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
      stall_reg  <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_next;
      // With one word held and the queue full, a single further word still
      // fits, so stall now to cover the cycle the partner needs to react.
      stall_reg <= (count_next == 2'(SKID_DEPTH)) |
                   ((count_next == 2'd1) & full);
    end
  end

endmodule

// File: rtl/eth_rx.sv
// Two-port Ethernet receiver. Each port classifies incoming words against
// the accepted destination addresses and feeds its own queue through a
// two-entry skid buffer. Ports are fully independent.
// Optional statistics counters are built when ETH_RX_STATS_EN is defined.
module eth_rx
  import eth_pkg::*;
#(
  parameter logic [0:1][31:0] PORT_ADDR = {32'h0, 32'h1}
)
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_valid    [0:1],
  input  logic [31:0]        i_data     [0:1],
  input  logic               i_start    [0:1],
  input  logic               i_end      [0:1],
  input  logic               full       [0:1],
  output logic               wr_en      [0:1],
  output logic [QWORD_W-1:0] wr_data    [0:1],
  output logic               port_stall [0:1]
`ifdef ETH_RX_STATS_EN
  ,
  output logic [CNT_W-1:0]   rx_pkt_cnt [0:1],
  output logic [CNT_W-1:0]   drop_cnt   [0:1],
  output logic [CNT_W-1:0]   err_cnt    [0:1]
`endif
);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port

      rx_states           state_reg;
      rx_states           state_next;
      logic               push;
      logic [QWORD_W-1:0] push_data;
      logic               addr_hit;
      logic               pkt_inc;
      logic               drop_inc;
      logic               err_inc;
      logic               overflow;

      assign addr_hit = (i_data[gi] == PORT_ADDR[0]) |
                        (i_data[gi] == PORT_ADDR[1]);

      // Classify the incoming word and pick the next FSM state
      always_comb begin
        state_next = state_reg;
        push       = 1'b0;
        push_data  = '0;
        pkt_inc    = 1'b0;
        drop_inc   = 1'b0;
        err_inc    = 1'b0;
        case (state_reg)
          IDLE: begin
            if (i_valid[gi]) begin
              if (i_start[gi]) begin
                if (addr_hit) begin
                  push      = 1'b1;
                  push_data = {i_end[gi], 1'b1, i_data[gi]};
                  if (i_end[gi]) begin
                    pkt_inc = 1'b1;
                  end else begin
                    state_next = RX;
                  end
                end else begin
                  drop_inc = 1'b1;
                  if (!i_end[gi]) begin
                    state_next = DROP;
                  end
                end
              end else begin
                // Word with no open packet
                err_inc = 1'b1;
              end
            end
          end
          RX: begin
            if (i_valid[gi]) begin
              push = 1'b1;
              if (i_start[gi]) begin
                // A new start closes the open packet on this word; the
                // rest of the new packet is discarded.
                push_data  = {1'b1, 1'b0, i_data[gi]};
                err_inc    = 1'b1;
                state_next = i_end[gi] ? IDLE : DROP;
              end else begin
                push_data = {i_end[gi], 1'b0, i_data[gi]};
                if (i_end[gi]) begin
                  pkt_inc    = 1'b1;
                  state_next = IDLE;
                end
              end
            end
          end
          DROP: begin
            if (i_valid[gi] && i_end[gi]) begin
              state_next = IDLE;
            end
          end
          default: begin
            state_next = IDLE;
          end
        endcase
      end

      // FSM state register
      always_ff @(posedge clk) begin
        if (!rstn) begin
          state_reg <= IDLE;
        end else begin
          state_reg <= state_next;
        end
      end

      eth_rx_skid u_skid (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (push_data),
        .full      (full[gi]),
        .wr_en     (wr_en[gi]),
        .wr_data   (wr_data[gi]),
        .stall     (port_stall[gi]),
        .overflow  (overflow)
      );

`ifdef ETH_RX_STATS_EN
      logic [CNT_W-1:0] rx_pkt_reg;
      logic [CNT_W-1:0] drop_reg;
      logic [CNT_W-1:0] err_reg;

      // Saturating per-port statistics; one increment per cycle at most
      always_ff @(posedge clk) begin
        if (!rstn) begin
          rx_pkt_reg <= '0;
          drop_reg   <= '0;
          err_reg    <= '0;
        end else begin
          rx_pkt_reg <= sat_inc(rx_pkt_reg, pkt_inc);
          drop_reg   <= sat_inc(drop_reg, drop_inc);
          err_reg    <= sat_inc(err_reg, err_inc | overflow);
        end
      end

      assign rx_pkt_cnt[gi] = rx_pkt_reg;
      assign drop_cnt[gi]   = drop_reg;
      assign err_cnt[gi]    = err_reg;
`else
      // Event strobes only feed the optional counters
      logic unused_stats;
      assign unused_stats = &{1'b0, pkt_inc, drop_inc, err_inc, overflow};
`endif

    end
  endgenerate

endmodule

// File: tb/tb_eth_rx.sv
// Directed testbench for eth_rx with a per-port scoreboard of queue writes.
module tb_eth_rx;
  import eth_pkg::*;

  logic               clk = 1'b0;
  logic               rstn;
  logic               i_valid    [0:1];
  logic [31:0]        i_data     [0:1];
  logic               i_start    [0:1];
  logic               i_end      [0:1];
  logic               full       [0:1];
  logic               wr_en      [0:1];
  logic [QWORD_W-1:0] wr_data    [0:1];
  logic               port_stall [0:1];
`ifdef ETH_RX_STATS_EN
  logic [CNT_W-1:0]   rx_pkt_cnt [0:1];
  logic [CNT_W-1:0]   drop_cnt   [0:1];
  logic [CNT_W-1:0]   err_cnt    [0:1];
`endif

  int checks = 0;
  int errors = 0;
  logic [QWORD_W-1:0] exp_q0 [$];
  logic [QWORD_W-1:0] exp_q1 [$];
  int   wr_seen [2];
  logic last_wr [2];

  always #5 clk = ~clk;

  eth_rx dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .i_start    (i_start),
    .i_end      (i_end),
    .full       (full),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .port_stall (port_stall)
`ifdef ETH_RX_STATS_EN
    ,
    .rx_pkt_cnt (rx_pkt_cnt),
    .drop_cnt   (drop_cnt),
    .err_cnt    (err_cnt)
`endif
  );

  task automatic check(input string tag, input logic [QWORD_W-1:0] obs,
                       input logic [QWORD_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_stats(input int p, input int rx, input int dr, input int er);
`ifdef ETH_RX_STATS_EN
    check($sformatf("rx_pkt_cnt%0d", p), 34'(rx_pkt_cnt[p]), 34'(rx));
    check($sformatf("drop_cnt%0d", p),   34'(drop_cnt[p]),   34'(dr));
    check($sformatf("err_cnt%0d", p),    34'(err_cnt[p]),    34'(er));
`endif
  endtask

  task automatic drive(input int p, input logic v, input logic s,
                       input logic e, input logic [31:0] d);
    i_valid[p] = v;
    i_start[p] = s;
    i_end[p]   = e;
    i_data[p]  = d;
  endtask

  task automatic expect_word(input int p, input logic e, input logic s,
                             input logic [31:0] d);
    if (p == 0) exp_q0.push_back({e, s, d});
    else        exp_q1.push_back({e, s, d});
  endtask

  // One clock: score outputs at the falling edge, return just after the rise
  task automatic step();
    logic [QWORD_W-1:0] w;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      last_wr[p] = wr_en[p];
      if (rstn) begin
        if (full[p]) check($sformatf("wr_en_while_full%0d", p), 34'(wr_en[p]), 34'd0);
        if (wr_en[p]) begin
          wr_seen[p]++;
          checks++;
          assert ((p == 0 ? exp_q0.size() : exp_q1.size()) > 0) else begin
            errors++;
            $error("FAIL unexpected_write%0d: observed write %h expected none", p, wr_data[p]);
          end
          if (p == 0 && exp_q0.size() > 0) begin
            w = exp_q0.pop_front();
            check("p0_word", wr_data[0], w);
          end else if (p == 1 && exp_q1.size() > 0) begin
            w = exp_q1.pop_front();
            check("p1_word", wr_data[1], w);
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    int base0;
    int base1;
    logic s;
    logic e;
    logic [31:0] d;

    rstn = 1'b0;
    for (int p = 0; p < 2; p++) begin
      drive(p, 1'b0, 1'b0, 1'b0, 32'h0);
      full[p]    = 1'b0;
      wr_seen[p] = 0;
      last_wr[p] = 1'b0;
    end
    repeat (3) step();

    // Reset state
    for (int p = 0; p < 2; p++) begin
      check($sformatf("rst_wr_en%0d", p),   34'(wr_en[p]), 34'd0);
      check($sformatf("rst_wr_data%0d", p), wr_data[p], 34'd0);
      check($sformatf("rst_stall%0d", p),   34'(port_stall[p]), 34'd0);
      check_stats(p, 0, 0, 0);
    end
    rstn = 1'b1;
    step();

    // Single packet on port 0, one-cycle latency
    drive(0, 1'b1, 1'b1, 1'b0, 32'h1);           expect_word(0, 1'b0, 1'b1, 32'h1);
    step();
    drive(0, 1'b1, 1'b0, 1'b0, 32'hA5A5_0001);   expect_word(0, 1'b0, 1'b0, 32'hA5A5_0001);
    step();
    check("lat_w0", 34'(last_wr[0]), 34'd1);
    drive(0, 1'b1, 1'b0, 1'b1, 32'hA5A5_0002);   expect_word(0, 1'b1, 1'b0, 32'hA5A5_0002);
    step();
    check("lat_w1", 34'(last_wr[0]), 34'd1);
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("lat_w2", 34'(last_wr[0]), 34'd1);
    step();
    check("single_no_extra", 34'(last_wr[0]), 34'd0);
    check("single_q_empty", 34'(exp_q0.size()), 34'd0);
    check_stats(0, 1, 0, 0);

    // Bad address: whole packet dropped, then a good packet goes through
    base0 = wr_seen[0];
    drive(0, 1'b1, 1'b1, 1'b0, 32'h7);          step();
    drive(0, 1'b1, 1'b0, 1'b0, 32'h1111_0001);  step();
    drive(0, 1'b1, 1'b0, 1'b0, 32'h1111_0002);  step();
    drive(0, 1'b1, 1'b0, 1'b1, 32'h1111_0003);  step();
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0);          step();
    step();
    check("bad_addr_no_write", 34'(wr_seen[0] - base0), 34'd0);
    check_stats(0, 1, 1, 0);
    drive(0, 1'b1, 1'b1, 1'b0, 32'h0);          expect_word(0, 1'b0, 1'b1, 32'h0);
    step();
    drive(0, 1'b1, 1'b0, 1'b1, 32'hBEEF_0001);  expect_word(0, 1'b1, 1'b0, 32'hBEEF_0001);
    step();
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(); step();
    check("after_drop_q_empty", 34'(exp_q0.size()), 34'd0);
    check_stats(0, 2, 1, 0);

    // Backpressure: full held for 5 cycles mid-packet, upstream obeys stall
    idx = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      full[0] = (cyc >= 3) && (cyc < 8);
      if (!port_stall[0] && idx < 8) begin
        s = (idx == 0);
        e = (idx == 7);
        d = (idx == 0) ? 32'h1 : 32'hB000_0000 + 32'(idx);
        drive(0, 1'b1, s, e, d);
        expect_word(0, e, s, d);
        idx++;
      end else begin
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
      end
      step();
      if (cyc >= 3 && cyc <= 7) check($sformatf("bp_stall_high_c%0d", cyc), 34'(port_stall[0]), 34'd1);
      if (cyc == 8)             check("bp_stall_fall", 34'(port_stall[0]), 34'd0);
    end
    full[0] = 1'b0;
    check("bp_all_sent", 34'(idx), 34'd8);
    check("bp_q_empty", 34'(exp_q0.size()), 34'd0);
    check_stats(0, 3, 1, 0);

    // Protocol errors: start inside a packet, then an orphan word
    drive(0, 1'b1, 1'b1, 1'b0, 32'h1);          expect_word(0, 1'b0, 1'b1, 32'h1);
    step();
    drive(0, 1'b1, 1'b0, 1'b0, 32'hD000_0001);  expect_word(0, 1'b0, 1'b0, 32'hD000_0001);
    step();
    drive(0, 1'b1, 1'b1, 1'b0, 32'h1);          expect_word(0, 1'b1, 1'b0, 32'h1);
    step();
    check_stats(0, 3, 1, 1);
    drive(0, 1'b1, 1'b0, 1'b0, 32'hD000_0002);  step();
    drive(0, 1'b1, 1'b0, 1'b1, 32'hD000_0003);  step();
    drive(0, 1'b1, 1'b0, 1'b0, 32'hD000_0004);  step();
    check_stats(0, 3, 1, 2);
    drive(0, 1'b1, 1'b1, 1'b1, 32'h0);          expect_word(0, 1'b1, 1'b1, 32'h0);
    step();
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(); step();
    check("perr_q_empty", 34'(exp_q0.size()), 34'd0);
    check_stats(0, 4, 1, 2);

    // Reset with one word parked in the skid
    full[0] = 1'b1;
    drive(0, 1'b1, 1'b1, 1'b0, 32'h1);
    step();
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("pre_rst_stall", 34'(port_stall[0]), 34'd1);
    rstn = 1'b0;
    step();
    full[0] = 1'b0;
    #1;
    check("mid_rst_wr_en", 34'(wr_en[0]), 34'd0);
    check("mid_rst_stall", 34'(port_stall[0]), 34'd0);
    check_stats(0, 0, 0, 0);
    rstn = 1'b1;
    step();
    // A start word must be taken as a fresh packet from IDLE
    drive(0, 1'b1, 1'b1, 1'b1, 32'h1);          expect_word(0, 1'b1, 1'b1, 32'h1);
    step();
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(); step();
    check("post_rst_q_empty", 34'(exp_q0.size()), 34'd0);
    check_stats(0, 1, 0, 0);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();

    // Both ports: single-word packets every cycle for 20 cycles
    base0 = wr_seen[0];
    base1 = wr_seen[1];
    for (int c = 0; c < 20; c++) begin
      for (int p = 0; p < 2; p++) begin
        drive(p, 1'b1, 1'b1, 1'b1, 32'h0);
        expect_word(p, 1'b1, 1'b1, 32'h0);
      end
      step();
    end
    for (int p = 0; p < 2; p++) drive(p, 1'b0, 1'b0, 1'b0, 32'h0);
    step(); step();
    check("dual_writes0", 34'(wr_seen[0] - base0), 34'd20);
    check("dual_writes1", 34'(wr_seen[1] - base1), 34'd20);
    check("dual_q0_empty", 34'(exp_q0.size()), 34'd0);
    check("dual_q1_empty", 34'(exp_q1.size()), 34'd0);
    check_stats(0, 20, 0, 0);
    check_stats(1, 20, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
